sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Two-into-one arbiter that shares the single SRAM-like request port of the AXI bridge between the instruction-fetch and data-access requesters. It chooses one requester per transaction and locks that grant until the address handshake completes. It records the source and type of every accepted transaction in an in-order tag FIFO so that each response is routed back to the correct requester. It also blocks data reads while a data write is still outstanding, and guarantees the instruction requester cannot be starved.

## Interface
- OUTSTANDING, 2: depth of the tag FIFO; the maximum number of accepted but unanswered transactions (1–4).
- STARVE_LIMIT, 4: consecutive cycles an instruction request may be denied before it is forced to win.
- aclk  in  1  clock; all state updates on the rising edge.
- areset  in  1  synchronous, active-high reset.
- inst_req / inst_wr  in  1 / 1  instruction request valid / write flag.
- inst_size / inst_wstrb  in  2 / 4  instruction access size / byte strobes.
- inst_addr / inst_wdata  in  32 / 32  instruction address / write data.
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction address accepted / response returned.
- inst_rdata  out  32  instruction read data (copy of m_rdata).
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1,1,2,4,32,32  data requester, same meaning as the inst_* inputs.
- data_addr_ok / data_data_ok  out  1 / 1  data address accepted / response returned.
- data_rdata  out  32  data read data (copy of m_rdata).
- m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1,1,2,4,32,32  request toward the bridge.
- m_addr_ok / m_data_ok  in  1 / 1  bridge address accept / response; responses arrive in issue order.
- m_rdata  in  32  bridge read data.
- err  out  1  sticky flag; set when a response arrives with no transaction outstanding.

## Operation
- **State machine**
  - IDLE: no grant is locked; the arbiter picks a winner combinationally.
  - HOLD: grant is locked to the registered source `gsel`.
  - IDLE→HOLD when m_req is high and m_addr_ok is low.
  - HOLD→IDLE on m_addr_ok.
  - IDLE stays in IDLE when m_req and m_addr_ok occur in the same cycle.
- **Eligibility**
  - Instruction requester is eligible when inst_req=1.
  - Data requester is eligible when data_req=1, and either data_wr=1 or no write is in the FIFO (wr_cnt=0).
  - Neither requester is eligible while the FIFO is full.
- **Priority in IDLE**
  - Data wins by default.
  - Instruction wins instead when starve_cnt ≥ STARVE_LIMIT.
- **Starvation counter (starve_cnt)**
  - Increments on each cycle where inst_req=1 and the instruction requester is not granted; saturates.
  - Clears on an instruction grant, and on any cycle with inst_req=0.
- **Request output**
  - m_req = winner present (IDLE) or locked source still requesting (HOLD).
  - m_* fields are muxed from the selected source; all are 0 when m_req=0.
  - In HOLD, if the locked source drops its req, m_req=0 and the FSM stays in HOLD.
- **Address handshake**
  - inst_addr_ok = m_req & m_addr_ok & (selected==inst).
  - data_addr_ok = m_req & m_addr_ok & (selected==data).
  - On this handshake, push {src, wr} into the tag FIFO.
- **Response routing**
  - On m_data_ok, pop the FIFO head and pulse the data_ok of head.src.
  - If head.wr=1, decrement wr_cnt; wr_cnt increments on each pushed write.
- **Boundary conditions**
  - Push and pop in the same cycle: count unchanged, including when the FIFO is full. Full still blocks a new grant that cycle.
  - m_data_ok while the FIFO is empty: no data_ok pulse is generated and err is set.
  - Pointers wrap modulo OUTSTANDING; count width is clog2(OUTSTANDING+1).

## Timing
- **Latency**
  - Zero-cycle combinational path from a request to m_req, and from m_addr_ok/m_data_ok to the requester's addr_ok/data_ok.
  - No registers in the data path.
- **Register updates**
  - FIFO, wr_cnt, starve_cnt and FSM update at the clock edge following the handshake.
  - A data read waiting on a write becomes eligible in the cycle after the write's m_data_ok.
- **Reset values** (areset=1 at a clock edge)
  - FSM=IDLE; FIFO empty; wr_cnt=0; starve_cnt=0; err=0.
  - All outputs 0 while no request is present, except that inst_rdata and data_rdata always follow m_rdata.
- **Reset mid-operation**
  - All outstanding tags are discarded.
  - Subsequent m_data_ok pulses for pre-reset transactions set err and produce no data_ok.

## Test plan
- **Simultaneous requests:** inst_req=data_req=1 (both reads), m_addr_ok=1 every cycle → data_addr_ok first. The grant then alternates per the starvation rule: inst_addr_ok no later than cycle STARVE_LIMIT+1 = 5.
- **Grant lock:** data read granted, m_addr_ok held low 3 cycles, then inst_req rises → m_addr follows data_addr for all 3 cycles; data_addr_ok on cycle 4; inst_addr_ok never before.
- **Write before read:** data write to 0x1c00_0000 accepted, then data read to the same address, bridge response 5 cycles later → m_req stays 0 for the read until the cycle after the write's m_data_ok. Write response → data_data_ok only.
- **Full FIFO and response routing:** OUTSTANDING=2; accept inst read and data read with no response → third request sees m_req=0. Two m_data_ok pulses → inst_data_ok, then data_data_ok; next request is accepted in the same cycle as the second pop.
- **Spurious response and reset recovery:** m_data_ok with the FIFO empty → err=1, no data_ok pulse. areset pulse with 2 transactions outstanding → err=0, FIFO empty, next inst read accepted normally.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares the single SRAM-like request port of the AXI bridge between the
// instruction-fetch and data-access requesters. One requester is chosen per
// transaction and the grant is locked until the address handshake finishes.
// Every accepted transaction leaves a {src, wr} tag in an in-order FIFO so the
// in-order responses can be steered back to their owner. Data reads are held
// off while any data write is still unanswered, and an instruction request
// that keeps losing is eventually forced to win.
//
// Ports
//   aclk, areset                 clock, synchronous active-high reset
//   inst_* / data_* (inputs)     requester req, wr, size, wstrb, addr, wdata
//   inst_/data_addr_ok           address accepted for that requester
//   inst_/data_data_ok           response returned to that requester
//   inst_/data_rdata             read data, straight copy of m_rdata
//   m_req .. m_wdata             request toward the bridge (0 when idle)
//   m_addr_ok, m_data_ok         bridge address accept / in-order response
//   m_rdata                      bridge read data
//   err                          sticky: response seen with nothing pending
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        err
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 2);

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic            gsel;
    logic            sel;

    logic [CW-1:0]   count;
    logic [CW-1:0]   wr_cnt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            fifo_src [OUTSTANDING];
    logic            fifo_wr  [OUTSTANDING];
    logic [SW-1:0]   starve_cnt;

    logic            full;
    logic            empty;
    logic            inst_elig;
    logic            data_elig;
    logic            inst_starved;
    logic            push;
    logic            pop;
    logic            head_src;
    logic            head_wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full         = (count == CW'(OUTSTANDING));
        empty        = (count == '0);
        inst_elig    = inst_req & ~full;
        // A read must not overtake an unanswered write; writes may queue.
        data_elig    = data_req & (data_wr | (wr_cnt == '0)) & ~full;
        inst_starved = (starve_cnt >= SW'(STARVE_LIMIT));
    end

    // Winner selection and FSM next state.
    always_comb begin
        sel       = SRC_INST;
        m_req     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (inst_elig && inst_starved) begin
                    sel   = SRC_INST;
                    m_req = 1'b1;
                end else if (data_elig) begin
                    sel   = SRC_DATA;
                    m_req = 1'b1;
                end else if (inst_elig) begin
                    sel   = SRC_INST;
                    m_req = 1'b1;
                end
                if (m_req && !m_addr_ok) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Locked source may withdraw; we keep the lock regardless.
                sel   = gsel;
                m_req = (gsel == SRC_DATA) ? data_req : inst_req;
                if (m_addr_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_wr    = m_req & ((sel == SRC_DATA) ? data_wr : inst_wr);
        m_size  = m_req ? ((sel == SRC_DATA) ? data_size  : inst_size)  : '0;
        m_wstrb = m_req ? ((sel == SRC_DATA) ? data_wstrb : inst_wstrb) : '0;
        m_addr  = m_req ? ((sel == SRC_DATA) ? data_addr  : inst_addr)  : '0;
        m_wdata = m_req ? ((sel == SRC_DATA) ? data_wdata : inst_wdata) : '0;

        push         = m_req & m_addr_ok;
        inst_addr_ok = push & (sel == SRC_INST);
        data_addr_ok = push & (sel == SRC_DATA);

        head_src     = fifo_src[rd_ptr];
        head_wr      = fifo_wr[rd_ptr];
        // A response with an empty FIFO is dropped here and flagged via err.
        pop          = m_data_ok & ~empty;
        inst_data_ok = pop & (head_src == SRC_INST);
        data_data_ok = pop & (head_src == SRC_DATA);

        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            gsel       <= SRC_INST;
            count      <= '0;
            wr_cnt     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == HOLD) begin
                gsel <= sel;
            end

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count  <= count + CW'(push) - CW'(pop);
            wr_cnt <= wr_cnt + CW'(push & m_wr) - CW'(pop & head_wr);

            if (!inst_req || (m_req && sel == SRC_INST)) begin
                starve_cnt <= '0;
            end else if (!inst_starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (m_data_ok && empty) begin
                err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind valid count.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_src[wr_ptr] <= sel;
            fifo_wr[wr_ptr]  <= m_wr;
        end
    end

endmodule
